// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised RW SRAM.
// Lane geometry and parity helpers used by the array and read pipe.
package sram_pkg;

    localparam int MAX_LANE_W = 1024;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } sram_state_t;

    function automatic int lane_w(
        input int data_w,
        input int mask_w
    );
        return data_w / mask_w;
    endfunction

    // Even parity of one lane; callers zero-extend narrower lanes.
    function automatic logic parity_lanes(
        input logic [MAX_LANE_W-1:0] lane
    );
        return ^lane;
    endfunction

endpackage

// File: rtl/sram_rw_param_if.sv
// Request/response bundle of the single RW port.
// master drives requests, slave is the SRAM.
interface sram_rw_param_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256,
    parameter int MASK_W = 32
);

    logic              en;
    logic              wmode;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              ready;
    logic [MASK_W-1:0] perr;

    modport master (
        output en, wmode, addr, wmask, wdata,
        input  rdata, rvalid, ready, perr
    );

    modport slave (
        input  en, wmode, addr, wmask, wdata,
        output rdata, rvalid, ready, perr
    );

endinterface

// File: rtl/sram_rw_param_rd_pipe.sv
// RD_LAT-deep pipeline for read valid, data and parity error.
// Output data holds until the next completed read.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int MASK_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic [MASK_W-1:0] p_in,
    output logic              v_out,
    output logic [DATA_W-1:0] d_out,
    output logic [MASK_W-1:0] p_out
);

    logic              v_q [RD_LAT];
    logic [DATA_W-1:0] d_q [RD_LAT];
    logic [MASK_W-1:0] p_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            v_q[0] <= v_in;
            if (v_in) begin
                d_q[0] <= d_in;
                p_q[0] <= p_in;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                    p_q[i] <= p_q[i-1];
                end
            end
        end
    end

    assign v_out = v_q[RD_LAT-1];
    assign d_out = d_q[RD_LAT-1];
    assign p_out = v_out ? p_q[RD_LAT-1] : '0;

endmodule

// File: rtl/sram_rw_param.sv
// Single-port RW SRAM with lane mask, post-reset clear and read pipe.
// Optional per-lane parity when SRAM_PARITY_EN is defined.
module sram_rw_param
    import sram_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 256,
    parameter int MASK_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic           RW0_clk,
    input  logic           RW0_rst_n,
    sram_rw_param_if.slave RW0
);

    localparam int LANE_W = lane_w(DATA_W, MASK_W);
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef SRAM_PARITY_EN
    localparam int PAR_W  = MASK_W;
`else
    localparam int PAR_W  = 0;
`endif
    localparam int ARR_W  = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    if (DATA_W % MASK_W != 0) begin : g_bad_mask
        $error("DATA_W must be a multiple of MASK_W");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("RD_LAT must be 1 or 2");
    end
    if (LANE_W > MAX_LANE_W) begin : g_bad_lane
        $error("lane wider than MAX_LANE_W");
    end

    logic [ARR_W-1:0]  mem [DEPTH];
    sram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              clr_we;
    logic              ready;
    logic              wr_fire;
    logic              rd_fire;
    logic [ARR_W-1:0]  wr_word;
    logic [ARR_W-1:0]  wr_bits;
    logic [ARR_W-1:0]  rd_word;
    logic [MASK_W-1:0] rd_perr;

`ifdef SRAM_PARITY_EN
    logic flip_par;
    assign flip_par = 1'b0;
`endif

    assign RW0.ready = ready;
    assign wr_fire   = ready & RW0.en & RW0.wmode;
    assign rd_fire   = ready & RW0.en & ~RW0.wmode;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Build the masked write as a word plus a bit-enable vector.
    always_comb begin
        wr_word = '0;
        wr_bits = '0;
        wr_word[DATA_W-1:0] = RW0.wdata;
        for (int i = 0; i < MASK_W; i++) begin
            wr_bits[i*LANE_W +: LANE_W] = {LANE_W{RW0.wmask[i]}};
`ifdef SRAM_PARITY_EN
            wr_word[DATA_W+i] = flip_par ^ parity_lanes(
                MAX_LANE_W'(RW0.wdata[i*LANE_W +: LANE_W]));
            wr_bits[DATA_W+i] = RW0.wmask[i];
`endif
        end
    end

    // Array contents are never reset; only the clear sequence zeroes them.
    always_ff @(posedge RW0_clk) begin
        if (clr_we) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_fire) begin
            mem[RW0.addr] <= (mem[RW0.addr] & ~wr_bits)
                           | (wr_word & wr_bits);
        end
    end

    assign rd_word = mem[RW0.addr];

    always_comb begin
        rd_perr = '0;
`ifdef SRAM_PARITY_EN
        for (int i = 0; i < MASK_W; i++) begin
            rd_perr[i] = rd_word[DATA_W+i] ^ parity_lanes(
                MAX_LANE_W'(rd_word[i*LANE_W +: LANE_W]));
        end
`endif
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .MASK_W (MASK_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk   (RW0_clk),
        .rst_n (RW0_rst_n),
        .v_in  (rd_fire),
        .d_in  (rd_word[DATA_W-1:0]),
        .p_in  (rd_perr),
        .v_out (RW0.rvalid),
        .d_out (RW0.rdata),
        .p_out (RW0.perr)
    );

endmodule

// File: tb/tb_sram_rw_param.sv
// Scoreboard bench for sram_rw_param (ADDR_W=4, 64-bit, 8 lanes, RD_LAT=2).
// Reads push expected data/perr/cycle; the monitor pops on rvalid.
module tb_sram_rw_param;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int RL = 2;
`ifdef SRAM_PARITY_EN
    localparam logic [MW-1:0] PE = 8'h04;
`else
    localparam logic [MW-1:0] PE = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_rw_param_if #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .MASK_W (MW)
    ) bus ();

    sram_rw_param #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MASK_W     (MW),
        .RD_LAT     (RL),
        .INIT_CLEAR (1)
    ) dut (
        .RW0_clk   (clk),
        .RW0_rst_n (rst_n),
        .RW0       (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [MW-1:0] p;
        int            c;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (bus.rvalid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_unexpected: rvalid=1 at cycle %0d, required no pulse",
                         cyc);
            end else begin
                e = sb.pop_front();
                if (bus.rdata !== e.d || bus.perr !== e.p || cyc != e.c) begin
                    miscompares++;
                    $display("FAIL read: rdata=%h perr=%h cycle=%0d, required rdata=%h perr=%h cycle=%0d",
                             bus.rdata, bus.perr, cyc, e.d, e.p, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] m);
        bus.en    = 1'b1;
        bus.wmode = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        bus.wmask = m;
        @(negedge clk);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] p);
        exp_t e;
        bus.en    = 1'b1;
        bus.wmode = 1'b0;
        bus.addr  = a;
        e.d = d;
        e.p = p;
        e.c = cyc + RL;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        bus.en = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // Counts sampled cycles with ready low; optionally fires junk requests.
    task automatic clear_wait(input bit junk, output int cnt);
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            if (junk) begin
                bus.en    = 1'b1;
                bus.wmode = cnt[0];
                bus.addr  = '0;
                bus.wdata = '1;
                bus.wmask = '1;
            end
            cnt++;
            @(negedge clk);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        bus.en    = 1'b0;
        bus.wmode = 1'b0;
        bus.addr  = '0;
        bus.wmask = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus.rdata, 64'h0);
        check("rst_rvalid", 64'(bus.rvalid), 64'h0);
        check("rst_perr", 64'(bus.perr), 64'h0);
        check("rst_ready", 64'(bus.ready), 64'h0);

        rst_n = 1'b1;
        clear_wait(1'b1, n);
        check("clear_cycles", 64'(n), 64'd16);
        check("ready_after_clear", 64'(bus.ready), 64'h1);

        for (int a = 0; a < 16; a++) begin
            rd(AW'(a), 64'h0, 8'h00);
        end
        idle(4);

        wr(4'd15, 64'hCAFE_F00D_1234_5678, 8'hFF);
        bus.en    = 1'b1;
        bus.wmode = 1'b0;
        bus.addr  = 4'd15;
        @(negedge clk);
        rst_n  = 1'b0;
        bus.en = 1'b0;
        check("inflight_rvalid0", 64'(bus.rvalid), 64'h0);
        @(negedge clk);
        check("inflight_rvalid1", 64'(bus.rvalid), 64'h0);
        check("inflight_ready", 64'(bus.ready), 64'h0);

        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midclear_ready", 64'(bus.ready), 64'h0);
        rst_n = 1'b1;
        clear_wait(1'b0, n);
        check("reclear_cycles", 64'(n), 64'd16);
        rd(4'd15, 64'h0, 8'h00);
        idle(3);

        wr(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(4'd3, 64'h1122_3344_5566_7788, 8'h0F);
        wr(4'd3, 64'h0123_4567_0000_0000, 8'h00);
        wr(4'd4, 64'h1122_3344_5566_7788, 8'h81);
        rd(4'd3, 64'hFFFF_FFFF_5566_7788, 8'h00);
        rd(4'd4, 64'h1100_0000_0000_0088, 8'h00);
        idle(3);

        wr(4'd1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wr(4'd2, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        idle(1);
        rd(4'd1, 64'h0123_4567_89AB_CDEF, 8'h00);
        rd(4'd2, 64'hDEAD_BEEF_0BAD_F00D, 8'h00);
        rd(4'd3, 64'hFFFF_FFFF_5566_7788, 8'h00);
        idle(5);
        check("rdata_hold", bus.rdata, 64'hFFFF_FFFF_5566_7788);
        check("rvalid_idle", 64'(bus.rvalid), 64'h0);

        wr(4'd5, 64'h0000_0000_0000_00A5, 8'hFF);
        rd(4'd5, 64'h0000_0000_0000_00A5, 8'h00);
        idle(3);

        wr(4'd0, 64'h8000_0000_0000_0001, 8'hFF);
        wr(4'd15, 64'h7FFF_FFFF_FFFF_FFFE, 8'hFF);
        rd(4'd15, 64'h7FFF_FFFF_FFFF_FFFE, 8'h00);
        rd(4'd0, 64'h8000_0000_0000_0001, 8'h00);
        idle(3);

`ifdef SRAM_PARITY_EN
        force dut.flip_par = 1'b1;
`endif
        wr(4'd7, 64'h0000_0000_00AB_0000, 8'h04);
`ifdef SRAM_PARITY_EN
        release dut.flip_par;
`endif
        wr(4'd8, 64'h0000_0000_0000_CD00, 8'h02);
        rd(4'd7, 64'h0000_0000_00AB_0000, PE);
        rd(4'd8, 64'h0000_0000_0000_CD00, 8'h00);
        idle(2);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
